parity_frame_rx: RTL
====================

PARITY_FRAME_RX -- requirements
Module: parity_frame_rx

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the number of data bits per frame (legal range 1..16).
REQ-002 Parameter ODD_PARITY, default 0, SHALL select the parity sense: 0 = even, 1 = odd.
REQ-003 Parameter CNT_W, default 8, SHALL set the width of the error counter.
REQ-004 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 bit_en  input  1  SHALL be the bit-sample strobe; rx is sampled only on edges where bit_en=1.
REQ-007 rx  input  1  SHALL be the serial line (idle high); frame order is start(0), data LSB-first, parity, stop(1).
REQ-008 err_clr  input  1  SHALL synchronously clear err_count.
REQ-009 data_out  output  DATA_W  SHALL carry the last received data word.
REQ-010 data_valid  output  1  SHALL pulse high for one clk cycle per completed frame.
REQ-011 parity_err  output  1  SHALL flag a parity mismatch in the last completed frame.
REQ-012 frame_err  output  1  SHALL flag a stop bit sampled as 0 in the last completed frame.
REQ-013 err_count  output  CNT_W  SHALL count frames with parity_err or frame_err set.

Function
REQ-014 The FSM SHALL have the states IDLE, DATA, PARITY and STOP; no state advances on edges where bit_en=0.
REQ-015 IDLE: on bit_en=1 and rx=0, go to DATA and clear the bit counter; rx=1 stays in IDLE.
REQ-016 DATA: each sampled bit SHALL shift in LSB-first; after the DATA_W-th sample, go to PARITY.
REQ-017 PARITY: sample the parity bit, go to STOP.
REQ-018 STOP: sample the stop bit, go to IDLE unconditionally, with either rx value.
REQ-019 Parity check: parity_err = (XOR of DATA_W data bits XOR parity bit) != ODD_PARITY.
REQ-020 On the edge that samples the stop bit, data_out, parity_err and frame_err SHALL be registered and data_valid set to 1; the outputs are visible in the following cycle (latency one clk after the stop sample).
REQ-021 data_valid SHALL clear on the next edge; data_out, parity_err and frame_err SHALL hold until the next completed frame.
REQ-022 Frames with errors SHALL still produce data_valid and update data_out.
REQ-023 err_count SHALL increment by exactly 1 per completed frame with parity_err or frame_err set, and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-024 If err_clr=1 on the same edge as an increment, the clear SHALL win and err_count becomes 0.
REQ-025 A start bit SHALL be accepted on the first bit_en edge after STOP, so back-to-back frames are received without loss.
REQ-026 rx is assumed to be synchronous to clk; no synchroniser is included.

Reset
REQ-027 While rst=1, the FSM SHALL be in IDLE, the bit counter and shift register at 0, and data_out, data_valid, parity_err, frame_err and err_count all at 0.
REQ-028 A reset asserted mid-frame SHALL discard the partial frame with no data_valid; reception resumes at the next start bit after release.

Verification (DATA_W=8, ODD_PARITY=0 unless noted)
REQ-029 Send frame 0xA5, parity 0, stop 1, with bit_en=1 every cycle -> one data_valid pulse 11 samples after the start bit, data_out=0xA5, parity_err=0, frame_err=0, err_count=0.
REQ-030 Send 0x07 with parity 0, stop 1 -> parity_err=1, data_out=0x07, err_count=1; then send 0x07 with parity 1 -> parity_err=0, err_count stays 1.
REQ-031 Send 0x3C with parity 0 and stop 0 -> frame_err=1, parity_err=0, err_count +1; the next valid frame 0x55 is received correctly.
REQ-032 Send 0xA5 with bit_en=1 only every 4th cycle and random rx toggling between strobes -> identical result to REQ-029, and data_valid lasts exactly one cycle.
REQ-033 CNT_W=2: send 5 bad-parity frames -> err_count sequence 1,2,3,3,3; then err_clr coinciding with a 6th bad frame -> err_count=0.
REQ-034 Assert rst after 4 data bits of a frame, then release and send 0x81 -> no data_valid for the aborted frame, then data_out=0x81, parity_err=0.

Source files
------------

// File: rtl/parity_frame_rx_if.sv
// Bus bundle for parity_frame_rx: serial line and strobe in, received frame and error status out.
interface parity_frame_rx_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              bit_en;
  logic              rx;
  logic              err_clr;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output bit_en, rx, err_clr,
    input  data_out, data_valid, parity_err, frame_err, err_count
  );

  modport slave (
    input  bit_en, rx, err_clr,
    output data_out, data_valid, parity_err, frame_err, err_count
  );
endinterface

// File: rtl/parity_frame_rx.sv
// Strobe-sampled serial frame receiver: start, LSB-first data, parity, stop.
// Reports each completed frame with a one-cycle valid pulse and keeps a saturating error count.
module parity_frame_rx #(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = 8
) (
  input logic clk,
  input logic rst,
  parity_frame_rx_if.slave bus
);
  localparam int BW = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t            state;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              par_bit;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              perr_q;
  logic              ferr_q;
  logic [CNT_W-1:0]  err_cnt_q;

  logic stop_edge;
  logic par_bad;
  logic stop_bad;
  logic cnt_full;

  assign stop_edge = bus.bit_en && (state == STOP);
  assign par_bad   = ((^shift_reg) ^ par_bit) != 1'(ODD_PARITY);
  assign stop_bad  = ~bus.rx;
  assign cnt_full  = &err_cnt_q;

  // Frame sequencing; the valid pulse self-clears on every edge regardless of the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (bus.bit_en) begin
        unique case (state)
          IDLE: begin
            if (!bus.rx) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift_reg <= (shift_reg >> 1) | (DATA_W'(bus.rx) << (DATA_W - 1));
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == BW'(DATA_W - 1)) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            par_bit <= bus.rx;
            state   <= STOP;
          end
          STOP: begin
            data_q  <= shift_reg;
            perr_q  <= par_bad;
            ferr_q  <= stop_bad;
            valid_q <= 1'b1;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Saturating error counter; a clear on the same edge as a bad frame wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (bus.err_clr) begin
      err_cnt_q <= '0;
    end else if (stop_edge && (par_bad || stop_bad) && !cnt_full) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.err_count  = err_cnt_q;
endmodule
